// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg: shared segment patterns, bit order and off levels for the 7-segment display path.
package seg_scan_driver_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high patterns indexed by hex code, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [3:0] AN_OFF_H  = 4'h0;
    localparam logic [6:0] SEG_OFF_H = 7'h00;
    localparam logic       DP_OFF_H  = 1'b0;

endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: digit codes, masks and blanking in; anode/segment/dp pins out.
interface seg_scan_driver_if;
    logic [3:0] SEL_3;
    logic [3:0] SEL_2;
    logic [3:0] SEL_1;
    logic [3:0] SEL_0;
    logic [3:0] BLINK_MASK;
    logic [3:0] DP_MASK;
    logic       BLANK_EN;
    logic [3:0] AN;
    logic [6:0] SEG;
    logic       DP;

    modport master (
        output SEL_3, SEL_2, SEL_1, SEL_0, BLINK_MASK, DP_MASK, BLANK_EN,
        input  AN, SEG, DP
    );

    modport slave (
        input  SEL_3, SEL_2, SEL_1, SEL_0, BLINK_MASK, DP_MASK, BLANK_EN,
        output AN, SEG, DP
    );
endinterface

// File: rtl/seg_scan_driver_seg7_decode.sv
// seg7_decode: combinational hex code to active-high 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);
    assign o_seg = SEG_PATTERNS[i_code];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes four hex digits onto a common-anode display
// with per-digit blink, decimal points and global blanking.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_driver_if.slave bus
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] r_pre;
    logic [BW-1:0] r_blink;
    logic          r_phase;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_tick;
    logic          w_blink_wrap;
    logic [1:0]    w_next_idx;
    logic [3:0]    w_code;
    logic [6:0]    w_pat;
    logic          w_dark;
    logic [3:0]    w_an_h;
    logic [6:0]    w_seg_h;
    logic          w_dp_h;

    assign w_tick       = r_pre == PW'(REFRESH_DIV - 1);
    assign w_blink_wrap = r_blink == BW'(BLINK_DIV - 1);
    assign w_next_idx   = r_idx + 2'd1;

    always_comb begin
        w_code = w_next_idx == 2'd0 ? bus.SEL_0 :
                 w_next_idx == 2'd1 ? bus.SEL_1 :
                 w_next_idx == 2'd2 ? bus.SEL_2 : bus.SEL_3;
        w_dark  = bus.BLANK_EN || (r_phase && bus.BLINK_MASK[w_next_idx]);
        w_an_h  = w_dark ? AN_OFF_H : 4'b0001 << w_next_idx;
        w_seg_h = w_dark ? SEG_OFF_H : w_pat;
        w_dp_h  = w_dark ? DP_OFF_H : bus.DP_MASK[w_next_idx];
    end

    seg7_decode u_decode (
        .i_code (w_code),
        .o_seg  (w_pat)
    );

    // Polarity is folded in only here, so everything upstream stays active-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_blink <= '0;
            r_phase <= 1'b0;
            r_idx   <= 2'd3;
            r_an    <= AN_OFF_H ^ {4{ACTIVE_LOW}};
            r_seg   <= SEG_OFF_H ^ {7{ACTIVE_LOW}};
            r_dp    <= DP_OFF_H ^ ACTIVE_LOW;
        end else begin
            r_pre   <= w_tick ? '0 : r_pre + 1'b1;
            r_blink <= w_blink_wrap ? '0 : r_blink + 1'b1;
            r_phase <= r_phase ^ w_blink_wrap;
            if (w_tick) begin
                r_idx <= w_next_idx;
                r_an  <= w_an_h ^ {4{ACTIVE_LOW}};
                r_seg <= w_seg_h ^ {7{ACTIVE_LOW}};
                r_dp  <= w_dp_h ^ ACTIVE_LOW;
            end
        end
    end

    assign bus.AN  = r_an;
    assign bus.SEG = r_seg;
    assign bus.DP  = r_dp;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: cycle-count reference model plus directed literal pins and random stimulus.
module tb_seg_scan_driver;
    localparam int R = 4;
    localparam int B = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    int t = 0;
    int cyc = 0;
    logic [11:0] e_out = 12'hFFF;

    logic [6:0] hi_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    always #5 clk = ~clk;

    seg_scan_driver_if bus ();

    seg_scan_driver #(.REFRESH_DIV(R), .BLINK_DIV(B), .ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Slot n starts at cycle n*R+R-1 after release and shows digit n mod 4;
    // blink phase at that cycle is floor(c/B) mod 2.
    function automatic logic [11:0] slot_out(int c);
        int i;
        logic [3:0] codes [4];
        logic [3:0] an;
        logic dark;
        i = (c / R) % 4;
        codes[0] = bus.SEL_0;
        codes[1] = bus.SEL_1;
        codes[2] = bus.SEL_2;
        codes[3] = bus.SEL_3;
        dark = bus.BLANK_EN || ((((c / B) % 2) == 1) && bus.BLINK_MASK[i]);
        an = ~(4'b0001 << i);
        return dark ? 12'hFFF : {an, ~hi_tbl[codes[i]], ~bus.DP_MASK[i]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc   <= 0;
            e_out <= 12'hFFF;
        end else begin
            if (cyc % R == R - 1) e_out <= slot_out(cyc);
            cyc <= cyc + 1;
        end
    end

    task automatic chk(string name, logic [11:0] got, logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %b expected %b", name, t, got, exp);
        end
    endtask

    always @(negedge clk) chk("model", {bus.AN, bus.SEG, bus.DP}, e_out);

    task automatic step(int n);
        repeat (n) @(negedge clk);
        t += n;
    endtask

    task automatic wait_to(int tt);
        step(tt - t);
    endtask

    task automatic set_base();
        bus.SEL_3 = 4'd1;
        bus.SEL_2 = 4'd2;
        bus.SEL_1 = 4'd3;
        bus.SEL_0 = 4'd4;
        bus.BLINK_MASK = 4'b0000;
        bus.DP_MASK = 4'b0000;
        bus.BLANK_EN = 1'b0;
    endtask

    initial begin
        set_base();
        step(2);
        chk("reset_off", {bus.AN, bus.SEG, bus.DP}, 12'hFFF);
        rst_n = 1'b1;
        t = 0;
        wait_to(3);
        chk("pre_first_slot", {8'h00, bus.AN}, 12'h00F);
        wait_to(4);
        chk("slot_d0", {1'b0, bus.AN, bus.SEG}, {1'b0, 4'b1110, 7'b0011001});
        wait_to(8);
        chk("slot_d1", {1'b0, bus.AN, bus.SEG}, {1'b0, 4'b1101, 7'b0110000});
        wait_to(12);
        chk("slot_d2", {1'b0, bus.AN, bus.SEG}, {1'b0, 4'b1011, 7'b0100100});
        wait_to(16);
        chk("slot_d3", {1'b0, bus.AN, bus.SEG}, {1'b0, 4'b0111, 7'b1111001});
        wait_to(20);
        chk("slot_d0_again", {1'b0, bus.AN, bus.SEG}, {1'b0, 4'b1110, 7'b0011001});
        wait_to(21);
        bus.SEL_0 = 4'd5;
        wait_to(37);
        chk("mid_slot_before", {5'd0, bus.SEG}, {5'd0, 7'b0010010});
        bus.SEL_0 = 4'd7;
        wait_to(39);
        chk("mid_slot_hold", {5'd0, bus.SEG}, {5'd0, 7'b0010010});
        wait_to(52);
        chk("mid_slot_next", {5'd0, bus.SEG}, {5'd0, 7'b1111000});
        for (int k = 0; k < 16; k++) begin
            wait_to(53 + 16 * k);
            bus.SEL_0 = 4'(k);
            wait_to(68 + 16 * k);
            if (k == 8) chk("decode_8", {5'd0, bus.SEG}, {5'd0, 7'b0000000});
            if (k == 15) chk("decode_F", {5'd0, bus.SEG}, {5'd0, 7'b0001110});
        end
        wait_to(309);
        bus.BLINK_MASK = 4'b0011;
        bus.DP_MASK = 4'b0100;
        wait_to(324);
        chk("blink_lit_d0", {8'h00, bus.AN}, 12'h00E);
        wait_to(340);
        chk("blink_dark_d0", {bus.AN, bus.SEG, bus.DP}, 12'hFFF);
        wait_to(344);
        chk("blink_dark_d1", {8'h00, bus.AN}, 12'h00F);
        wait_to(348);
        chk("blink_d2_dp", {7'd0, bus.AN, bus.DP}, {7'd0, 4'b1011, 1'b0});
        wait_to(352);
        chk("blink_d3_nodp", {7'd0, bus.AN, bus.DP}, {7'd0, 4'b0111, 1'b1});
        wait_to(363);
        bus.BLANK_EN = 1'b1;
        wait_to(364);
        bus.BLANK_EN = 1'b0;
        chk("blank_start", {bus.AN, bus.SEG, bus.DP}, 12'hFFF);
        wait_to(367);
        chk("blank_hold", {bus.AN, bus.SEG, bus.DP}, 12'hFFF);
        wait_to(368);
        chk("blank_after", {8'h00, bus.AN}, 12'h007);
        repeat (3000) begin
            step(1);
            if ($urandom_range(0, 3) == 0) begin
                bus.SEL_0 = 4'($urandom);
                bus.SEL_1 = 4'($urandom);
                bus.SEL_2 = 4'($urandom);
                bus.SEL_3 = 4'($urandom);
                bus.BLINK_MASK = 4'($urandom);
                bus.DP_MASK = 4'($urandom);
                bus.BLANK_EN = $urandom_range(0, 7) == 0;
            end
        end
        step(1);
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_slot", {bus.AN, bus.SEG, bus.DP}, 12'hFFF);
        @(negedge clk);
        set_base();
        rst_n = 1'b1;
        t = 0;
        wait_to(3);
        chk("restart_off", {8'h00, bus.AN}, 12'h00F);
        wait_to(4);
        chk("restart_d0", {1'b0, bus.AN, bus.SEG}, {1'b0, 4'b1110, 7'b0011001});
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
